acorn_tag_gen: RTL

//   ACORN-128 finalization stage, directly downstream of the encryption stage.

---
 rtl/acorn_pkg.sv | 79 +++++++
 rtl/acorn_tag_ctrl.sv | 79 +++++++
 rtl/acorn_tag_gen.sv | 78 +++++++
 3 files changed

// File: rtl/acorn_pkg.sv
// Shared ACORN-128 constants, FSM type and the round primitives (LFSR mix,
// keystream generator, feedback, full StateUpdate128) used by every stage.
package acorn_pkg;

  localparam int unsigned ACORN_STATE_W   = 293;
  localparam int unsigned ACORN_TAG_W     = 128;
  localparam int unsigned ACORN_FIN_STEPS = 768;
  localparam int unsigned ACORN_CNT_W     = 10;
  localparam int unsigned ACORN_TAG_IDX_W = 7;

  // LFSR boundary taps shared with the init and encryption stages
  localparam int unsigned TAP_0   = 0;
  localparam int unsigned TAP_107 = 107;
  localparam int unsigned TAP_154 = 154;
  localparam int unsigned TAP_193 = 193;
  localparam int unsigned TAP_230 = 230;
  localparam int unsigned TAP_244 = 244;
  localparam int unsigned TAP_292 = 292;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acorn_fsm_e;

  function automatic logic acorn_maj(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic acorn_ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // Six LFSR boundary updates; every right-hand side uses the pre-step value.
  function automatic logic [ACORN_STATE_W-1:0] acorn_lfsr_mix(
    input logic [ACORN_STATE_W-1:0] s
  );
    logic [ACORN_STATE_W-1:0] t;
    t          = s;
    t[289]     = s[289]     ^ s[235] ^ s[TAP_230];
    t[TAP_230] = s[TAP_230] ^ s[196] ^ s[TAP_193];
    t[TAP_193] = s[TAP_193] ^ s[160] ^ s[TAP_154];
    t[TAP_154] = s[TAP_154] ^ s[111] ^ s[TAP_107];
    t[TAP_107] = s[TAP_107] ^ s[66]  ^ s[61];
    t[61]      = s[61]      ^ s[23]  ^ s[TAP_0];
    return t;
  endfunction

  function automatic logic acorn_ksg128(input logic [ACORN_STATE_W-1:0] t);
    return t[12] ^ t[TAP_154] ^ acorn_maj(t[235], t[61], t[TAP_193])
         ^ acorn_ch(t[TAP_230], t[111], t[66]);
  endfunction

  function automatic logic acorn_fbk128(
    input logic [ACORN_STATE_W-1:0] t,
    input logic ks,
    input logic ca,
    input logic cb
  );
    return t[TAP_0] ^ ~t[TAP_107] ^ acorn_maj(t[TAP_244], t[23], t[160])
         ^ (ca & t[196]) ^ (cb & ks);
  endfunction

  function automatic logic [ACORN_STATE_W-1:0] acorn_state_update128(
    input logic [ACORN_STATE_W-1:0] s,
    input logic m,
    input logic ca,
    input logic cb
  );
    logic [ACORN_STATE_W-1:0] t;
    logic ks;
    logic f;
    t  = acorn_lfsr_mix(s);
    ks = acorn_ksg128(t);
    f  = acorn_fbk128(t, ks, ca, cb);
    return {f ^ m, t[TAP_292:1]};
  endfunction

endpackage

// File: rtl/acorn_tag_ctrl.sv
// Finalization sequencer: IDLE/RUN/DONE FSM plus the 10-bit step counter.
module acorn_tag_ctrl
  import acorn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_load_c,
  output logic [ACORN_CNT_W-1:0] o_count
);

  localparam logic [ACORN_CNT_W-1:0] LAST_STEP = ACORN_CNT_W'(ACORN_FIN_STEPS - 1);

  acorn_fsm_e             r_state;
  acorn_fsm_e             w_state_nxt;
  logic [ACORN_CNT_W-1:0] r_count;
  logic [ACORN_CNT_W-1:0] w_count_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   w_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // busy/done are registered images of the next state, so they track RUN/DONE exactly
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = RUN;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        w_count_nxt = r_count + ACORN_CNT_W'(1);
        if (r_count == LAST_STEP) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_load_c = w_load;
  assign o_count  = r_count;

endmodule

// File: rtl/acorn_tag_gen.sv
// ACORN-128 finalization: 768 StateUpdate128 steps (m=0, ca=cb=1), last 128
// keystream bits form the tag. Optional tag compare under ACORN_TAG_CHECK_EN.
module acorn_tag_gen
  import acorn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ACORN_STATE_W-1:0] state_in,
  output logic                     busy,
  output logic                     done,
  output logic [ACORN_TAG_W-1:0]   tag_out
`ifdef ACORN_TAG_CHECK_EN
  ,
  input  logic [ACORN_TAG_W-1:0]   tag_ref,
  output logic                     tag_ok
`endif
);

  localparam logic [ACORN_CNT_W-1:0] TAG_START = ACORN_CNT_W'(ACORN_FIN_STEPS - ACORN_TAG_W);

  logic [ACORN_STATE_W-1:0]   r_state;
  logic [ACORN_TAG_W-1:0]     r_tag;
  logic [ACORN_STATE_W-1:0]   w_state_nxt;
  logic                       w_ks;
  logic                       w_load;
  logic [ACORN_CNT_W-1:0]     w_count;
  logic [ACORN_TAG_IDX_W-1:0] w_tag_idx;

  acorn_tag_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_start  (start),
    .o_busy   (busy),
    .o_done   (done),
    .o_load_c (w_load),
    .o_count  (w_count)
  );

  assign w_ks        = acorn_ksg128(acorn_lfsr_mix(r_state));
  assign w_state_nxt = acorn_state_update128(r_state, 1'b0, 1'b1, 1'b1);
  assign w_tag_idx   = ACORN_TAG_IDX_W'(w_count - TAG_START);

  // busy is high exactly in RUN, so it doubles as the step enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= '0;
      r_tag   <= '0;
    end else if (w_load) begin
      r_state <= state_in;
      r_tag   <= '0;
    end else if (busy) begin
      r_state <= w_state_nxt;
      if (w_count >= TAG_START) begin
        r_tag[w_tag_idx] <= w_ks;
      end
    end
  end

  assign tag_out = r_tag;

`ifdef ACORN_TAG_CHECK_EN
  logic r_tag_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_ok <= 1'b0;
    end else if (w_load) begin
      r_tag_ok <= 1'b0;
    end else if (done) begin
      r_tag_ok <= (r_tag == tag_ref);
    end
  end

  assign tag_ok = r_tag_ok;
`endif

endmodule
